// File: rtl/reg_serializer.sv
// rtl/reg_serializer.sv - Parallel-to-serial framer: start bit, N data bits LSB first, optional even parity (SER_PARITY_EN), stop bit
module reg_serializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         l,
    input  logic [N-1:0] D,
    output logic         sout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SER_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t        state, state_d;
    logic [N-1:0]  shreg, shreg_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          sout_d, busy_d, done_d;

    // Next state plus the output values for the cycle that state will occupy,
    // so that sout/busy/done can be registered without adding latency.
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        cnt_d   = cnt;
        sout_d  = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (l) begin
                    shreg_d = D;
                    state_d = START;
                    sout_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                sout_d  = shreg[0];
            end
            DATA: begin
                if (cnt == LAST) begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
                    sout_d  = ^shreg;
`else
                    state_d = STOP;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d  = cnt + 1'b1;
                    sout_d = shreg[cnt_d];
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                state_d = STOP;
                done_d  = 1'b1;
            end
`endif
            STOP: begin
                // l is deliberately not looked at here; a held request
                // is taken on the following IDLE cycle.
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, data and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            sout  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            cnt   <= cnt_d;
            sout  <= sout_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

endmodule
